// File: rtl/result_distributor.sv
// result_distributor: show-ahead iteration queue mapped to RGB pixels with raster position and frame FSM
module result_distributor #(
  parameter int DEPTH    = 8,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ITER_W-1:0] push_iter,
  input  logic              frame_done,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [23:0]       out_data,
  output logic              out_user,
  output logic              out_last,
  output logic              full_queue,
  output logic              distributor_ready,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int XW = H_RES > 1 ? $clog2(H_RES) : 1;
  localparam int YW = V_RES > 1 ? $clog2(V_RES) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state, state_nxt;
  logic [ITER_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ITER_W-1:0] head;
  logic [7:0] lo;
  logic do_push, do_pop, x_end, y_end, resync;
  assign full_queue        = count == (AW+1)'(DEPTH);
  assign out_valid         = count != '0;
  assign do_push           = push && !full_queue;
  assign do_pop            = out_valid && out_ready;
  assign head              = mem[rp];
  assign lo                = 8'(head);
  assign out_data          = head == ITER_W'(MAX_ITER) ? 24'h000000 : {lo, lo, 8'hFF};
  assign x_end             = x == XW'(H_RES - 1);
  assign y_end             = y == YW'(V_RES - 1);
  assign out_user          = out_valid && x == '0 && y == '0;
  assign out_last          = out_valid && x_end;
  assign distributor_ready = state == FLUSH;
  assign resync            = state == FLUSH && state_nxt == IDLE;
  // Queue storage is left unreset; stale entries are unreachable once count is cleared
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= push_iter;
  // Pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wp       <= wp + AW'(do_push);
      rp       <= rp + AW'(do_pop);
      count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= overflow || (push && full_queue);
    end
  // Raster position follows transfers and is realigned to the frame origin when a flush completes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (resync) begin
      x <= '0;
      y <= '0;
    end else if (do_pop) begin
      x <= x_end ? '0 : x + XW'(1);
      if (x_end) y <= y_end ? '0 : y + YW'(1);
    end
  // Frame state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // Frame state transitions; frame_done only matters while streaming
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE   ? (do_push ? STREAM : IDLE) :
                state == STREAM ? (frame_done ? FLUSH : STREAM) :
                (count == '0 && !do_push) ? IDLE : FLUSH;
  end
endmodule

// File: tb/tb_result_distributor.sv
// tb_result_distributor: directed self-checking bench for result_distributor
module tb_result_distributor;
  logic clk = 1'b0, rst = 1'b0, push = 1'b0, frame_done = 1'b0, out_ready = 1'b0;
  logic [7:0] push_iter = '0;
  logic out_valid, out_user, out_last, full_queue, distributor_ready, overflow;
  logic [23:0] out_data;
  int checks = 0, errors = 0;

  result_distributor #(.DEPTH(8), .ITER_W(8), .MAX_ITER(255), .H_RES(4), .V_RES(2)) dut (
    .clk(clk), .rst(rst), .push(push), .push_iter(push_iter), .frame_done(frame_done),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_user(out_user),
    .out_last(out_last), .full_queue(full_queue), .distributor_ready(distributor_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    push = 0; frame_done = 0; out_ready = 0; push_iter = '0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic push_one(input logic [7:0] v);
    push = 1; push_iter = v;
    @(negedge clk);
    push = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (full_queue !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full_queue); end
    checks++; if (distributor_ready !== 1'b0) begin errors++; $display("FAIL reset_dready got %b exp 0", distributor_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1;
    push_one(8'd3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 24'h0303FF) begin errors++; $display("FAIL basic_data got %h exp 0303ff", out_data); end
    checks++; if (out_user !== 1'b1) begin errors++; $display("FAIL basic_user got %b exp 1", out_user); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL basic_last got %b exp 0", out_last); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) push_one(8'(10 + i));
    checks++; if (full_queue !== 1'b1) begin errors++; $display("FAIL full_after8 got %b exp 1", full_queue); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_after8 got %b exp 0", overflow); end
    push_one(8'd18);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after9 got %b exp 1", overflow); end
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== {8'(10 + i), 8'(10 + i), 8'hFF}) begin
        errors++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, {8'(10 + i), 8'(10 + i), 8'hFF});
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_push_pop_full();
    int n;
    logic [23:0] last_d;
    do_reset();
    for (int i = 0; i < 8; i++) push_one(8'(i));
    out_ready = 1;
    push_one(8'd99);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pp_overflow got %b exp 1", overflow); end
    checks++; if (full_queue !== 1'b0) begin errors++; $display("FAIL pp_full got %b exp 0", full_queue); end
    n = 0; last_d = '0;
    for (int t = 0; t < 20 && out_valid === 1'b1; t++) begin
      n++; last_d = out_data;
      @(negedge clk);
    end
    checks++; if (n != 7) begin errors++; $display("FAIL pp_count got %0d exp 7", n); end
    checks++; if (last_d !== 24'h0707FF) begin errors++; $display("FAIL pp_lastdata got %h exp 0707ff", last_d); end
  endtask

  task automatic test_raster();
    do_reset();
    for (int i = 0; i < 8; i++) push_one(8'(i));
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (out_user !== (i == 1) || out_last !== (i % 4 == 0)) begin
        errors++; $display("FAIL raster_%0d got user=%b last=%b exp user=%b last=%b", i, out_user, out_last, i == 1, i % 4 == 0);
      end
      @(negedge clk);
    end
    out_ready = 0;
    push_one(8'd1);
    checks++; if (out_user !== 1'b1 || out_last !== 1'b0) begin
      errors++; $display("FAIL raster_wrap got user=%b last=%b exp user=1 last=0", out_user, out_last);
    end
  endtask

  task automatic test_max_iter();
    do_reset();
    push_one(8'd255);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'h000000) begin
      errors++; $display("FAIL max_iter got v=%b d=%h exp v=1 d=000000", out_valid, out_data);
    end
    push_one(8'd254);
    out_ready = 1;
    @(negedge clk);
    checks++; if (out_data !== 24'hFEFEFF) begin errors++; $display("FAIL near_max got %h exp fefeff", out_data); end
  endtask

  task automatic test_flush();
    do_reset();
    frame_done = 1;
    @(negedge clk);
    frame_done = 0;
    checks++; if (distributor_ready !== 1'b0) begin errors++; $display("FAIL idle_fd got %b exp 0", distributor_ready); end
    for (int i = 0; i < 3; i++) push_one(8'(20 + i));
    frame_done = 1;
    @(negedge clk);
    frame_done = 0;
    checks++; if (distributor_ready !== 1'b1) begin errors++; $display("FAIL flush_enter got %b exp 1", distributor_ready); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (distributor_ready !== 1'b1) begin errors++; $display("FAIL flush_pop%0d got %b exp 1", i, distributor_ready); end
    end
    @(negedge clk);
    checks++; if (distributor_ready !== 1'b0) begin errors++; $display("FAIL flush_exit got %b exp 0", distributor_ready); end
    out_ready = 0;
    push_one(8'd5);
    checks++; if (out_user !== 1'b1 || out_last !== 1'b0) begin
      errors++; $display("FAIL flush_resync got user=%b last=%b exp user=1 last=0", out_user, out_last);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) push_one(8'(i));
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill got %b exp 1", out_valid); end
    #2 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || full_queue !== 1'b0) begin
      errors++; $display("FAIL mid_async got v=%b full=%b exp v=0 full=0", out_valid, full_queue);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_push_pop_full();
    test_raster();
    test_max_iter();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
